// File: rtl/rng_word_arbiter.sv
// Buffers one 512-bit ChaCha20 keystream block and hands out its sixteen 32-bit words,
// one per grant, to NUM_REQ requesters in round-robin order.
module rng_word_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int WORD_WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    input  logic [16*WORD_WIDTH-1:0] block_data,
    input  logic                     block_valid,
    output logic                     block_ready,
    input  logic [NUM_REQ-1:0]       req,
    output logic [NUM_REQ-1:0]       grant,
    output logic [WORD_WIDTH-1:0]    rnd_word,
    output logic                     rnd_valid
);

    localparam int BLOCK_W = 16 * WORD_WIDTH;
    localparam int LW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [LW-1:0] LAST_INIT = LW'(NUM_REQ - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        SERVE = 1'b1
    } state_t;

    state_t               state;
    state_t               next_state;
    logic [BLOCK_W-1:0]   buffer;
    logic [3:0]           idx;
    logic [LW-1:0]        last;

    logic                 any_req;
    logic [LW-1:0]        win;
    logic [NUM_REQ-1:0]   win_onehot;
    logic [WORD_WIDTH-1:0] cur_word;
    logic                 take_block;
    logic                 issue;

    assign any_req    = |req;
    assign block_ready = (state == EMPTY);
    assign take_block = (state == EMPTY) && block_valid;
    assign issue      = (state == SERVE) && any_req;
    assign cur_word   = buffer[{idx, 5'd0} +: WORD_WIDTH];

    // Round-robin search starting just after the last winner, wrapping once.
    always_comb begin
        logic found;
        int   cand;
        found = 1'b0;
        win   = last;
        cand  = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last) + k) % NUM_REQ;
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = LW'(cand);
            end
        end
    end

    always_comb begin
        win_onehot      = '0;
        win_onehot[win] = 1'b1;
    end

    always_comb begin
        next_state = state;
        case (state)
            EMPTY: if (block_valid) next_state = SERVE;
            SERVE: if (any_req && idx == 4'd15) next_state = EMPTY;
            default: next_state = EMPTY;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else if (clear) begin
            state <= EMPTY;
        end else begin
            state <= next_state;
        end
    end

    // Buffer, word index and round-robin pointer; outputs are registered with the grant.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            buffer    <= '0;
            idx       <= 4'd0;
            last      <= LAST_INIT;
            grant     <= '0;
            rnd_word  <= '0;
            rnd_valid <= 1'b0;
        end else if (clear) begin
            buffer    <= '0;
            idx       <= 4'd0;
            last      <= LAST_INIT;
            grant     <= '0;
            rnd_word  <= '0;
            rnd_valid <= 1'b0;
        end else begin
            grant     <= '0;
            rnd_valid <= 1'b0;
            if (take_block) begin
                buffer <= block_data;
                idx    <= 4'd0;
            end
            if (issue) begin
                grant     <= win_onehot;
                rnd_word  <= cur_word;
                rnd_valid <= 1'b1;
                last      <= win;
                idx       <= idx + 4'd1;
            end
        end
    end

endmodule
